// File: rtl/fft_frame_analyzer.sv
// rtl/fft_frame_analyzer.sv - FFT sink framing, magnitude-squared pipeline and per-frame peak search
// Optional build macro FFT_FA_DC_SKIP_EN removes bin 0 from the peak search.
module fft_frame_analyzer #(
    parameter int DATA_W        = 12,
    parameter int FFT_LEN       = 1024,
    parameter int LEN_W         = 10,
    parameter int GAP_CYCLES    = 1024,
    parameter int HALF_SPECTRUM = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  sink_valid,
    input  logic                  sink_ready,
    output logic                  sink_sop,
    output logic                  sink_eop,
    output logic [DATA_W-1:0]     sink_real,
    input  logic                  source_valid,
    input  logic                  source_sop,
    input  logic                  source_eop,
    input  logic [1:0]            source_error,
    input  logic [DATA_W-1:0]     source_real,
    input  logic [DATA_W-1:0]     source_imag,
    output logic                  mag_valid,
    output logic [2*DATA_W:0]     mag_out,
    output logic [LEN_W-1:0]      mag_bin,
    output logic                  peak_valid,
    output logic [LEN_W-1:0]      peak_bin,
    output logic [2*DATA_W:0]     peak_mag,
    output logic                  peak_err,
    output logic                  busy
);
    localparam int MAG_W = 2 * DATA_W + 1;
    localparam int SQ_W  = 2 * DATA_W;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   k_q, k_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               in_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                k_d = '0;
                if (enable) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (sample_valid && sink_ready) begin
                    if (k_q == LEN_W'(FFT_LEN - 1)) begin
                        k_d   = '0;
                        gap_d = '0;
                        if (GAP_CYCLES == 0) state_d = enable ? S_LOAD : S_IDLE;
                        else                 state_d = S_GAP;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = enable ? S_LOAD : S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_load      = (state_q == S_LOAD);
        sink_valid   = in_load & sample_valid;
        sink_real    = in_load ? sample_in : '0;
        sample_ready = in_load & sink_ready;
        sink_sop     = sink_valid & (k_q == '0);
        sink_eop     = sink_valid & (k_q == LEN_W'(FFT_LEN - 1));
        busy         = (state_q != S_IDLE);
    end

    // Source side: bin index of the current beat, then a two-stage |X|^2 pipeline.
    logic [LEN_W-1:0]   bin_q, cur_bin;
    logic               s1_valid_q, s1_sop_q, s1_eop_q, s1_err_q;
    logic [SQ_W-1:0]    s1_re2_q, s1_im2_q;
    logic [LEN_W-1:0]   s1_bin_q;
    logic               mag_valid_q, s2_sop_q, s2_eop_q, s2_err_q;
    logic [MAG_W-1:0]   mag_q;
    logic [LEN_W-1:0]   mag_bin_q;
    logic signed [SQ_W-1:0] re_sq, im_sq;

    assign cur_bin = source_sop ? '0 : bin_q;
    assign re_sq   = $signed(source_real) * $signed(source_real);
    assign im_sq   = $signed(source_imag) * $signed(source_imag);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_sop_q    <= 1'b0;
            s1_eop_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_re2_q    <= '0;
            s1_im2_q    <= '0;
            s1_bin_q    <= '0;
            mag_valid_q <= 1'b0;
            s2_sop_q    <= 1'b0;
            s2_eop_q    <= 1'b0;
            s2_err_q    <= 1'b0;
            mag_q       <= '0;
            mag_bin_q   <= '0;
        end else begin
            s1_valid_q  <= source_valid;
            mag_valid_q <= s1_valid_q;
            if (source_valid) begin
                bin_q    <= cur_bin + 1'b1;
                s1_re2_q <= re_sq;
                s1_im2_q <= im_sq;
                s1_bin_q <= cur_bin;
                s1_sop_q <= source_sop;
                s1_eop_q <= source_eop;
                s1_err_q <= (source_error != 2'b00);
            end
            if (s1_valid_q) begin
                mag_q     <= {1'b0, s1_re2_q} + {1'b0, s1_im2_q};
                mag_bin_q <= s1_bin_q;
                s2_sop_q  <= s1_sop_q;
                s2_eop_q  <= s1_eop_q;
                s2_err_q  <= s1_err_q;
            end
        end
    end

    logic               have_q, have_d, err_acc_q, err_acc_d, base_have, eligible;
    logic [LEN_W-1:0]   best_bin_q, best_bin_d, pk_bin_q, pk_bin_d;
    logic [MAG_W-1:0]   best_mag_q, best_mag_d, pk_mag_q, pk_mag_d;
    logic               pv_q, pv_d, pk_err_q, pk_err_d;

    always_comb begin
        eligible = 1'b1;
        if (HALF_SPECTRUM != 0 && mag_bin_q[LEN_W-1]) eligible = 1'b0;
`ifdef FFT_FA_DC_SKIP_EN
        if (mag_bin_q == '0) eligible = 1'b0;
`endif
        have_d     = have_q;
        err_acc_d  = err_acc_q;
        best_bin_d = best_bin_q;
        best_mag_d = best_mag_q;
        pv_d       = 1'b0;
        pk_bin_d   = pk_bin_q;
        pk_mag_d   = pk_mag_q;
        pk_err_d   = pk_err_q;
        base_have  = have_q;
        if (mag_valid_q) begin
            // A sop always starts a fresh search, abandoning any unfinished frame.
            if (s2_sop_q) begin
                base_have  = 1'b0;
                best_bin_d = '0;
                best_mag_d = '0;
                err_acc_d  = 1'b0;
            end
            have_d    = base_have;
            err_acc_d = err_acc_d | s2_err_q;
            if (eligible && (!base_have || mag_q > best_mag_q)) begin
                have_d     = 1'b1;
                best_bin_d = mag_bin_q;
                best_mag_d = mag_q;
            end
            if (s2_eop_q) begin
                pv_d      = 1'b1;
                pk_bin_d  = best_bin_d;
                pk_mag_d  = best_mag_d;
                pk_err_d  = err_acc_d;
                have_d    = 1'b0;
                err_acc_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            have_q     <= 1'b0;
            err_acc_q  <= 1'b0;
            best_bin_q <= '0;
            best_mag_q <= '0;
            pv_q       <= 1'b0;
            pk_bin_q   <= '0;
            pk_mag_q   <= '0;
            pk_err_q   <= 1'b0;
        end else begin
            have_q     <= have_d;
            err_acc_q  <= err_acc_d;
            best_bin_q <= best_bin_d;
            best_mag_q <= best_mag_d;
            pv_q       <= pv_d;
            pk_bin_q   <= pk_bin_d;
            pk_mag_q   <= pk_mag_d;
            pk_err_q   <= pk_err_d;
        end
    end

    assign mag_valid  = mag_valid_q;
    assign mag_out    = mag_q;
    assign mag_bin    = mag_bin_q;
    assign peak_valid = pv_q;
    assign peak_bin   = pk_bin_q;
    assign peak_mag   = pk_mag_q;
    assign peak_err   = pk_err_q;
endmodule

// File: tb/tb_fft_frame_analyzer.sv
// tb/tb_fft_frame_analyzer.sv - directed bench for fft_frame_analyzer (full and half spectrum instances)
module tb_fft_frame_analyzer;
    localparam int DW = 12;
    localparam int N  = 8;
    localparam int LW = 3;
    localparam int MW = 2 * DW + 1;
`ifdef FFT_FA_DC_SKIP_EN
    localparam bit DC_SKIP = 1'b1;
`else
    localparam bit DC_SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, enable, sample_valid, sink_ready;
    logic source_valid, source_sop, source_eop;
    logic [DW-1:0] sample_in, source_real, source_imag;
    logic [1:0] source_error;

    logic sample_ready_a, sink_valid_a, sink_sop_a, sink_eop_a, busy_a;
    logic mag_valid_a, peak_valid_a, peak_err_a;
    logic [DW-1:0] sink_real_a;
    logic [MW-1:0] mag_out_a, peak_mag_a;
    logic [LW-1:0] mag_bin_a, peak_bin_a;
    logic sample_ready_b, sink_valid_b, sink_sop_b, sink_eop_b, busy_b;
    logic mag_valid_b, peak_valid_b, peak_err_b;
    logic [DW-1:0] sink_real_b;
    logic [MW-1:0] mag_out_b, peak_mag_b;
    logic [LW-1:0] mag_bin_b, peak_bin_b;

    always #5 clk = ~clk;

    fft_frame_analyzer #(.DATA_W(DW), .FFT_LEN(N), .LEN_W(LW), .GAP_CYCLES(4), .HALF_SPECTRUM(0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready_a), .sink_valid(sink_valid_a), .sink_ready(sink_ready),
        .sink_sop(sink_sop_a), .sink_eop(sink_eop_a), .sink_real(sink_real_a),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_error(source_error), .source_real(source_real), .source_imag(source_imag),
        .mag_valid(mag_valid_a), .mag_out(mag_out_a), .mag_bin(mag_bin_a),
        .peak_valid(peak_valid_a), .peak_bin(peak_bin_a), .peak_mag(peak_mag_a),
        .peak_err(peak_err_a), .busy(busy_a));

    fft_frame_analyzer #(.DATA_W(DW), .FFT_LEN(N), .LEN_W(LW), .GAP_CYCLES(0), .HALF_SPECTRUM(1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready_b), .sink_valid(sink_valid_b), .sink_ready(sink_ready),
        .sink_sop(sink_sop_b), .sink_eop(sink_eop_b), .sink_real(sink_real_b),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_error(source_error), .source_real(source_real), .source_imag(source_imag),
        .mag_valid(mag_valid_b), .mag_out(mag_out_b), .mag_bin(mag_bin_b),
        .peak_valid(peak_valid_b), .peak_bin(peak_bin_b), .peak_mag(peak_mag_b),
        .peak_err(peak_err_b), .busy(busy_b));

    int checks = 0;
    int failures = 0;
    int fr_re [N];
    int fr_im [N];
    logic [1:0] fr_err [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
            fr_err[i] = 2'b00;
        end
    endtask

    task automatic drive_beat(input int b, input logic v);
        source_valid = v;
        source_sop   = v && (b == 0);
        source_eop   = v && (b == N - 1);
        source_real  = v ? DW'(fr_re[b]) : '0;
        source_imag  = v ? DW'(fr_im[b]) : '0;
        source_error = v ? fr_err[b] : 2'b00;
    endtask

    task automatic run_frame();
        for (int j = 0; j < 11; j++) begin
            step();
            drive_beat((j < N) ? j : 0, j < N);
            #1;
            if (j >= 2 && j < 10) begin
                check("mag_valid", 32'(mag_valid_a), 32'd1);
                check("mag_bin", 32'(mag_bin_a), 32'(j - 2));
                check("mag_out", 32'(mag_out_a),
                      32'(fr_re[j-2] * fr_re[j-2] + fr_im[j-2] * fr_im[j-2]));
            end
            check("peak_valid_a", 32'(peak_valid_a), 32'(j == 10));
            check("peak_valid_b", 32'(peak_valid_b), 32'(j == 10));
        end
    endtask

    task automatic check_peak(input string tag, input int ba, input int ma, input int ea,
                              input int bb, input int mb, input int eb);
        check({tag, "_bin_a"}, 32'(peak_bin_a), 32'(ba));
        check({tag, "_mag_a"}, 32'(peak_mag_a), 32'(ma));
        check({tag, "_err_a"}, 32'(peak_err_a), 32'(ea));
        check({tag, "_bin_b"}, 32'(peak_bin_b), 32'(bb));
        check({tag, "_mag_b"}, 32'(peak_mag_b), 32'(mb));
        check({tag, "_err_b"}, 32'(peak_err_b), 32'(eb));
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sink_ready = 1'b0; sample_in = '0;
        clear_frame();
        drive_beat(0, 1'b0);
        step(); step(); step();
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_sink_valid", 32'(sink_valid_a), 32'd0);
        check("rst_sample_ready", 32'(sample_ready_a), 32'd0);
        check("rst_mag_valid", 32'(mag_valid_a), 32'd0);
        check("rst_peak_valid", 32'(peak_valid_a), 32'd0);
        check("rst_peak_mag", 32'(peak_mag_a), 32'd0);

        // Continuous frames: A has 8 beats + 4 gap cycles, B has no gap.
        rst = 1'b0; enable = 1'b1; sample_valid = 1'b1; sink_ready = 1'b1;
        step();
        for (int j = 0; j < 15; j++) begin
            if (j > 0) step();
            sample_in = DW'(j + 100);
            #1;
            check("cont_sop_a", 32'(sink_sop_a), 32'((j % 12) == 0));
            check("cont_eop_a", 32'(sink_eop_a), 32'((j % 12) == 7));
            check("cont_ready_a", 32'(sample_ready_a), 32'((j % 12) < 8));
            check("cont_busy_a", 32'(busy_a), 32'd1);
            if ((j % 12) < 8) check("cont_real_a", 32'(sink_real_a), 32'(j + 100));
            check("cont_sop_b", 32'(sink_sop_b), 32'((j % 8) == 0));
            check("cont_eop_b", 32'(sink_eop_b), 32'((j % 8) == 7));
        end

        rst = 1'b1;
        step();
        check("midload_rst_busy_a", 32'(busy_a), 32'd0);
        check("midload_rst_busy_b", 32'(busy_b), 32'd0);
        check("midload_rst_valid_a", 32'(sink_valid_a), 32'd0);

        // Back-pressure: ready on even cycles only; enable dropped mid-frame.
        rst = 1'b0; enable = 1'b1;
        step();
        n = 0;
        for (int j = 0; j < 15; j++) begin
            if (j > 0) step();
            sink_ready = ((j % 2) == 0);
            if (j == 1) enable = 1'b0;
            #1;
            check("bp_sop_a", 32'(sink_sop_a), 32'(n == 0));
            check("bp_eop_a", 32'(sink_eop_a), 32'(n == 7));
            check("bp_ready_a", 32'(sample_ready_a), 32'(sink_ready));
            check("bp_sop_b", 32'(sink_sop_b), 32'(n == 0));
            check("bp_eop_b", 32'(sink_eop_b), 32'(n == 7));
            if (sink_ready) n++;
        end
        step();
        check("gap_busy_a", 32'(busy_a), 32'd1);
        check("gap_ready_a", 32'(sample_ready_a), 32'd0);
        check("gap_valid_a", 32'(sink_valid_a), 32'd0);
        check("nogap_idle_b", 32'(busy_b), 32'd0);
        step(); step(); step();
        check("gap_end_busy_a", 32'(busy_a), 32'd1);
        step();
        check("stop_idle_a", 32'(busy_a), 32'd0);
        sample_valid = 1'b0;

        // F1: single tone 3+4j at bin 5.
        clear_frame();
        fr_re[5] = 3; fr_im[5] = 4;
        run_frame();
        check_peak("f1", 5, 25, 0, DC_SKIP ? 1 : 0, 0, 0);

        // F2: tie of 100 at bins 2 and 6, lowest bin wins.
        clear_frame();
        fr_re[2] = 6; fr_im[2] = 8; fr_re[6] = 10;
        run_frame();
        check_peak("f2", 2, 100, 0, 2, 100, 0);

        // F3: peak only in the upper half.
        clear_frame();
        fr_re[6] = 10;
        run_frame();
        check_peak("f3", 6, 100, 0, DC_SKIP ? 1 : 0, 0, 0);

        // F4: full-scale negative inputs plus an error flag.
        clear_frame();
        fr_re[3] = -2048; fr_im[3] = -2048; fr_err[4] = 2'b01;
        run_frame();
        check_peak("f4", 3, 8388608, 1, 3, 8388608, 1);

        // Abandoned partial frame (large bin 1), then F5 with a DC component.
        clear_frame();
        fr_re[1] = 2047; fr_re[2] = 2047;
        for (int j = 0; j < 4; j++) begin
            step();
            drive_beat(j, 1'b1);
            source_eop = 1'b0;
            #1;
            check("abandon_peak_valid", 32'(peak_valid_a), 32'd0);
        end
        clear_frame();
        fr_re[0] = 100; fr_re[2] = 5;
        run_frame();
        check_peak("f5", DC_SKIP ? 2 : 0, DC_SKIP ? 25 : 10000, 0,
                   DC_SKIP ? 2 : 0, DC_SKIP ? 25 : 10000, 0);

        // Reset in the middle of a source frame.
        clear_frame();
        fr_re[0] = 50;
        for (int j = 0; j < 4; j++) begin
            step();
            drive_beat(j, 1'b1);
        end
        step();
        rst = 1'b1;
        drive_beat(0, 1'b0);
        step();
        check("srcrst_mag_valid", 32'(mag_valid_a), 32'd0);
        check("srcrst_mag_out", 32'(mag_out_a), 32'd0);
        check("srcrst_peak_valid", 32'(peak_valid_a), 32'd0);
        check("srcrst_peak_bin", 32'(peak_bin_a), 32'd0);
        check("srcrst_peak_mag", 32'(peak_mag_a), 32'd0);
        rst = 1'b0;
        clear_frame();
        fr_re[5] = 3; fr_im[5] = 4;
        run_frame();
        check_peak("after_rst", 5, 25, 0, DC_SKIP ? 1 : 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
